// File: rtl/shift_add_multiplier_datapath.sv
// shift_add_multiplier_datapath: sequential unsigned shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset, clears all state
//   load         start pulse; samples operands and (re)starts the operation
//   multiplicand operand M, sampled on load
//   multiplier   operand Q, sampled on load
//   product      registered result, valid while done=1
//   done         result valid, held until next load/reset
//   busy         high while iterating
//   count        high during the terminating iteration cycle
//   A            live accumulator (upper half of {A,Q})
// Optional feature: define SHIFT_ADD_EARLY_TERM_EN to finish as soon as the
// remaining multiplier bits are all zero.
module shift_add_multiplier_datapath #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic [2*WIDTH-1:0]   product,
   output logic                 done,
   output logic                 busy,
   output logic                 count,
   output logic [WIDTH-1:0]     A
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d, q_q, q_d, m_q, m_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH:0]     sum;
   logic               last;
`ifdef SHIFT_ADD_EARLY_TERM_EN
   logic               zero;
`endif
   always_comb begin
      sum     = {1'b0, a_q} + (q_q[0] ? {1'b0, m_q} : '0);
      last    = cnt_q == CW'(WIDTH - 1);
`ifdef SHIFT_ADD_EARLY_TERM_EN
      // after cnt shifts only the low WIDTH-cnt bits of Q are still multiplier bits
      zero    = (q_q & ({WIDTH{1'b1}} >> cnt_q)) == '0;
      count   = (state_q == RUN) && (last || zero);
`else
      count   = (state_q == RUN) && last;
`endif
      state_d = state_q;
      a_d     = a_q;
      q_d     = q_q;
      m_d     = m_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      if (load) begin
         state_d = RUN;
         a_d     = '0;
         q_d     = multiplier;
         m_d     = multiplicand;
         cnt_d   = '0;
      end else if (state_q == RUN) begin
`ifdef SHIFT_ADD_EARLY_TERM_EN
         if (zero) begin
            // partial product so far sits in {A, top cnt bits of Q}
            prod_d  = {a_q, q_q} >> (CW'(WIDTH) - cnt_q);
            state_d = DONE;
         end else
`endif
         begin
            // {C,A,Q} >> 1: carry lands in A's msb, sum lsb enters Q's msb
            {a_d, q_d} = {sum, q_q[WIDTH-1:1]};
            cnt_d      = cnt_q + CW'(1);
            if (last) begin
               prod_d  = {sum, q_q[WIDTH-1:1]};
               state_d = DONE;
            end
         end
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         q_q     <= '0;
         m_q     <= '0;
         cnt_q   <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         q_q     <= q_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
      end
   end
   assign product = prod_q;
   assign done    = state_q == DONE;
   assign busy    = state_q == RUN;
   assign A       = a_q;
endmodule

// File: tb/tb_shift_add_multiplier_datapath.sv
// tb_shift_add_multiplier_datapath: scoreboard bench for the shift-add multiplier
module tb_shift_add_multiplier_datapath;
   localparam int W = 8;
   logic           clk = 0, reset = 0, load = 0;
   logic [W-1:0]   mc = 0, mp = 0;
   logic [2*W-1:0] product;
   logic           done, busy, count;
   logic [W-1:0]   A;
   typedef struct {logic [2*W-1:0] p; int lat; int lc;} exp_t;
   exp_t q[$];
   int checks = 0, errors = 0, cyc = 0;
   shift_add_multiplier_datapath #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .load(load), .multiplicand(mc), .multiplier(mp),
      .product(product), .done(done), .busy(busy), .count(count), .A(A)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   function automatic int model_lat(input logic [W-1:0] b);
`ifdef SHIFT_ADD_EARLY_TERM_EN
      int n = 0;
      for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
      return (n + 1 > W) ? W : n + 1;
`else
      return W;
`endif
   endfunction
   logic done_p = 0;
   int   busy_n = 0, cnt_n = 0;
   always @(negedge clk) begin
      exp_t e;
      if (!reset || load) begin
         busy_n = 0;
         cnt_n  = 0;
      end else begin
         if (busy) busy_n++;
         if (count) cnt_n++;
      end
      if (done && !done_p) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got product %0d with nothing pending", product);
         end else begin
            e = q.pop_front();
            chk("product", product, e.p);
            chk("latency", cyc - e.lc, e.lat);
            chk("busy_cycles", busy_n, e.lat);
            chk("count_cycles", cnt_n, 1);
         end
      end
      done_p = done;
   end
   task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_done);
      @(posedge clk);
      #1 mc = a; mp = b; load = 1;
      @(posedge clk);
      #1 load = 0;
      if (expect_done) q.push_back('{(2*W)'(a) * (2*W)'(b), model_lat(b), cyc});
   endtask
   task automatic wait_done();
      int n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL timeout: done=%0d required 1", done);
         q.delete();
      end
   endtask
   initial begin
      logic [2*W-1:0] old;
      #12;
      chk("rst_product", product, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_count", count, 0);
      chk("rst_A", A, 0);
      @(posedge clk);
      #1 reset = 1;
      start(13, 11, 1);
      wait_done();
      start(255, 255, 1);
      wait_done();
      chk("A_at_done", A, 8'hFE);
      old = product;
      start(0, 200, 1);
      chk("done_drop", done, 0);
      chk("product_hold", product, old);
      wait_done();
      start(200, 0, 1);
      wait_done();
      start(20, 30, 0);
      repeat (2) @(posedge clk);
      start(7, 6, 1);
      wait_done();
      start(99, 99, 0);
      repeat (3) @(posedge clk);
      #1 reset = 0;
      #1;
      chk("arst_product", product, 0);
      chk("arst_done", done, 0);
      chk("arst_busy", busy, 0);
      chk("arst_count", count, 0);
      chk("arst_A", A, 0);
      @(posedge clk);
      #1 reset = 1;
      start(3, 5, 1);
      wait_done();
      start(200, 1, 1);
      wait_done();
      @(posedge clk);
      #1 mc = 5; mp = 9; load = 1;
      repeat (12) @(posedge clk);
      #1 load = 0;
      q.push_back('{16'd45, model_lat(9), cyc});
      wait_done();
      for (int i = 0; i < 1000; i++) begin
         start(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1);
         wait_done();
      end
      repeat (3) @(posedge clk);
      chk("queue_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
